// File: rtl/iq_split.sv
// Splits one paired I/Q AXI stream into independent I and Q AXI streams.
// Define IQ_SPLIT_SKID_EN for per-channel skid registers and a registered input_tready.
module iq_split #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_i_tdata,
  input  logic [WIDTH-1:0] input_q_tdata,
  input  logic             input_tvalid,
  output logic             input_tready,
  output logic [WIDTH-1:0] output_i_tdata,
  output logic             output_i_tvalid,
  input  logic             output_i_tready,
  output logic [WIDTH-1:0] output_q_tdata,
  output logic             output_q_tvalid,
  input  logic             output_q_tready
);

  logic             accept;
  logic [WIDTH-1:0] in_data  [2];
  logic [WIDTH-1:0] out_data [2];
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;

  assign in_data[0]      = input_i_tdata;
  assign in_data[1]      = input_q_tdata;
  assign out_ready       = {output_q_tready, output_i_tready};
  assign output_i_tdata  = out_data[0];
  assign output_q_tdata  = out_data[1];
  assign output_i_tvalid = out_valid[0];
  assign output_q_tvalid = out_valid[1];
  assign accept          = input_tvalid & input_tready;

`ifdef IQ_SPLIT_SKID_EN
  logic [1:0] occ_ok;
  logic       tready_reg;

  // Never advertise ready while reset is being applied, even if the register is still high.
  assign input_tready = tready_reg & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      tready_reg <= 1'b0;
    end else begin
      tready_reg <= &occ_ok;
    end
  end
`else
  assign input_tready = ~rst & (~out_valid[0] | out_ready[0]) & (~out_valid[1] | out_ready[1]);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [WIDTH-1:0] data_reg;
      logic             valid_reg;
      logic             drain;

      assign drain         = valid_reg & out_ready[gi];
      assign out_data[gi]  = data_reg;
      assign out_valid[gi] = valid_reg;

`ifdef IQ_SPLIT_SKID_EN
      logic [WIDTH-1:0] skid_data_reg;
      logic             skid_valid_reg;
      logic [1:0]       occ;
      logic [1:0]       occ_next;

      assign occ        = {1'b0, valid_reg} + {1'b0, skid_valid_reg};
      assign occ_next   = occ - {1'b0, drain} + {1'b0, accept};
      assign occ_ok[gi] = (occ_next <= 2'd1);

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg       <= '0;
          valid_reg      <= 1'b0;
          skid_data_reg  <= '0;
          skid_valid_reg <= 1'b0;
        end else if (drain) begin
          // The skid beat is older than the incoming one, so it moves forward first.
          if (skid_valid_reg) begin
            data_reg <= skid_data_reg;
            if (accept) begin
              skid_data_reg <= in_data[gi];
            end else begin
              skid_valid_reg <= 1'b0;
            end
          end else if (accept) begin
            data_reg <= in_data[gi];
          end else begin
            valid_reg <= 1'b0;
          end
        end else if (accept) begin
          if (valid_reg) begin
            skid_data_reg  <= in_data[gi];
            skid_valid_reg <= 1'b1;
          end else begin
            data_reg  <= in_data[gi];
            valid_reg <= 1'b1;
          end
        end
      end
`else
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else if (accept) begin
          data_reg  <= in_data[gi];
          valid_reg <= 1'b1;
        end else if (drain) begin
          valid_reg <= 1'b0;
        end
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_iq_split.sv
// Self-checking bench for iq_split: queue-based reference model plus directed and random traffic.
module tb_iq_split;

`ifdef IQ_SPLIT_SKID_EN
  localparam int MAXOCC = 2;
`else
  localparam int MAXOCC = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] input_i_tdata = '0;
  logic [15:0] input_q_tdata = '0;
  logic        input_tvalid = 1'b0;
  logic        input_tready;
  logic [15:0] output_i_tdata;
  logic        output_i_tvalid;
  logic        output_i_tready = 1'b1;
  logic [15:0] output_q_tdata;
  logic        output_q_tvalid;
  logic        output_q_tready = 1'b1;

  int checks = 0;
  int passed = 0;

  logic [15:0] qi[$];
  logic [15:0] qq[$];
  bit          model_ok = 1'b0;
  bit          tready_exp = 1'b0;
  bit          rand_done = 1'b0;

  iq_split #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .input_i_tdata(input_i_tdata),
    .input_q_tdata(input_q_tdata),
    .input_tvalid(input_tvalid),
    .input_tready(input_tready),
    .output_i_tdata(output_i_tdata),
    .output_i_tvalid(output_i_tvalid),
    .output_i_tready(output_i_tready),
    .output_q_tdata(output_q_tdata),
    .output_q_tvalid(output_q_tvalid),
    .output_q_tready(output_q_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
  endtask

  // Reference model: per-channel FIFO of accepted-but-undelivered beats.
  always @(posedge clk) begin
    bit acc;
    acc = input_tvalid && input_tready && !rst;
    if (rst) begin
      qi.delete();
      qq.delete();
      model_ok   = 1'b1;
      tready_exp = 1'b0;
    end else begin
      if (qi.size() != 0 && output_i_tready) void'(qi.pop_front());
      if (qq.size() != 0 && output_q_tready) void'(qq.pop_front());
      if (acc) begin
        qi.push_back(input_i_tdata);
        qq.push_back(input_q_tdata);
      end
      tready_exp = (qi.size() <= 1) && (qq.size() <= 1);
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    bit exp_rdy;
    int skew;
    if (model_ok) begin
`ifdef IQ_SPLIT_SKID_EN
      exp_rdy = tready_exp && !rst;
`else
      exp_rdy = !rst && (qi.size() == 0 || output_i_tready) && (qq.size() == 0 || output_q_tready);
`endif
      chk("i_valid", {31'd0, output_i_tvalid}, {31'd0, qi.size() != 0});
      chk("q_valid", {31'd0, output_q_tvalid}, {31'd0, qq.size() != 0});
      if (qi.size() != 0) chk("i_data", {16'd0, output_i_tdata}, {16'd0, qi[0]});
      if (qq.size() != 0) chk("q_data", {16'd0, output_q_tdata}, {16'd0, qq[0]});
      chk("in_tready", {31'd0, input_tready}, {31'd0, exp_rdy});
      skew = qi.size() - qq.size();
      if (skew < 0) skew = -skew;
      chk("skew_ok", {31'd0, skew <= MAXOCC}, 32'd1);
      chk("occ_ok", {31'd0, qi.size() <= MAXOCC && qq.size() <= MAXOCC}, 32'd1);
    end
  end

  task automatic send(input logic [15:0] i, input logic [15:0] q);
    bit accepted = 1'b0;
    input_i_tdata = i;
    input_q_tdata = q;
    input_tvalid  = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk);
      if (input_tready && !rst) begin
        accepted = 1'b1;
        break;
      end
    end
    chk("send_accept", {31'd0, accepted}, 32'd1);
    #1;
    input_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_valid", {31'd0, output_i_tvalid}, 32'd0);
    chk("rst_q_valid", {31'd0, output_q_tvalid}, 32'd0);
    chk("rst_i_data", {16'd0, output_i_tdata}, 32'd0);
    chk("rst_q_data", {16'd0, output_q_tdata}, 32'd0);
    chk("rst_tready", {31'd0, input_tready}, 32'd0);
    rst = 1'b0;
`ifdef IQ_SPLIT_SKID_EN
    idle(1);
    chk("tready_rise", {31'd0, input_tready}, 32'd1);
`endif

    // Basic pass-through
    send(16'h0001, 16'h8001);
    chk("basic_i0", {16'd0, output_i_tdata}, 32'h0001);
    chk("basic_q0", {16'd0, output_q_tdata}, 32'h8001);
    chk("basic_rdy0", {31'd0, input_tready}, 32'd1);
    send(16'h0002, 16'h8002);
    chk("basic_i1", {16'd0, output_i_tdata}, 32'h0002);
    chk("basic_q1", {16'd0, output_q_tdata}, 32'h8002);
    chk("basic_rdy1", {31'd0, input_tready}, 32'd1);
    send(16'h0003, 16'h8003);
    chk("basic_i2", {16'd0, output_i_tdata}, 32'h0003);
    chk("basic_q2", {16'd0, output_q_tdata}, 32'h8003);
    chk("basic_v2", {31'd0, output_i_tvalid & output_q_tvalid}, 32'd1);
    idle(2);

    // Q stall
    output_q_tready = 1'b0;
    send(16'h0010, 16'h0020);
    chk("qstall_i", {16'd0, output_i_tdata}, 32'h0010);
    fork
      send(16'h0011, 16'h0021);
      begin
        idle(3);
        chk("qstall_q_hold", {16'd0, output_q_tdata}, 32'h0020);
        chk("qstall_q_valid", {31'd0, output_q_tvalid}, 32'd1);
        chk("qstall_tready", {31'd0, input_tready}, 32'd0);
        output_q_tready = 1'b1;
      end
    join
    idle(2);
    chk("qstall_i_empty", {31'd0, output_i_tvalid}, 32'd0);
    chk("qstall_q_empty", {31'd0, output_q_tvalid}, 32'd0);

    // Data hold
    output_i_tready = 1'b0;
    send(16'h0055, 16'h0066);
    for (int k = 0; k < 5; k++) begin
      chk("hold_i_data", {16'd0, output_i_tdata}, 32'h0055);
      chk("hold_i_valid", {31'd0, output_i_tvalid}, 32'd1);
      idle(1);
    end
    output_i_tready = 1'b1;
    idle(2);

    // Reset mid-operation
    output_i_tready = 1'b0;
    output_q_tready = 1'b0;
    send(16'h0077, 16'h0088);
    idle(1);
    rst = 1'b1;
    idle(1);
    chk("mrst_i_valid", {31'd0, output_i_tvalid}, 32'd0);
    chk("mrst_q_valid", {31'd0, output_q_tvalid}, 32'd0);
    chk("mrst_i_data", {16'd0, output_i_tdata}, 32'd0);
    chk("mrst_q_data", {16'd0, output_q_tdata}, 32'd0);
    rst = 1'b0;
    output_i_tready = 1'b1;
    output_q_tready = 1'b1;
    send(16'h00AA, 16'h00BB);
    chk("mrst_next_i", {16'd0, output_i_tdata}, 32'h00AA);
    chk("mrst_next_q", {16'd0, output_q_tdata}, 32'h00BB);
    idle(2);

`ifdef IQ_SPLIT_SKID_EN
    // Registered tready with both outputs stalled
    output_i_tready = 1'b0;
    output_q_tready = 1'b0;
    send(16'h0101, 16'h0201);
    chk("skid_rdy_after1", {31'd0, input_tready}, 32'd1);
    send(16'h0102, 16'h0202);
    chk("skid_rdy_after2", {31'd0, input_tready}, 32'd0);
    fork
      send(16'h0103, 16'h0203);
      begin
        idle(3);
        chk("skid_rdy_stall", {31'd0, input_tready}, 32'd0);
        chk("skid_i_head", {16'd0, output_i_tdata}, 32'h0101);
        output_i_tready = 1'b1;
        output_q_tready = 1'b1;
      end
    join
    idle(4);
`endif

    // Random traffic with out-of-phase readys
    fork
      begin
        for (int b = 0; b < 100; b++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          send(16'($urandom), 16'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          output_i_tready = 1'($urandom_range(0, 1));
          output_q_tready = ~output_i_tready | ($urandom_range(0, 3) == 0);
        end
      end
    join
    output_i_tready = 1'b1;
    output_q_tready = 1'b1;
    idle(5);
    chk("final_i_empty", {31'd0, output_i_tvalid}, 32'd0);
    chk("final_q_empty", {31'd0, output_q_tvalid}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
